// File: rtl/lcd_power_sequencer.sv
// Ordered power-up / reverse power-down of N panel enable rails from one level request, with programmable dwell.
// Latency 1 edge from request to first rail change, all outputs registered; no backpressure, lcd_on may reverse at any edge.
module lcd_power_sequencer #(
  parameter int N_RAILS = 5,
  parameter int DLY_W   = 16,
  parameter int LVL_W   = $clog2(N_RAILS + 1)
) (
  input  logic               clk_out,
  input  logic               rst,
  input  logic               lcd_on,
  input  logic [DLY_W-1:0]   step_dly,
  output logic [N_RAILS-1:0] rails_en,
  output logic [LVL_W-1:0]   lvl,
  output logic               lcd_ready,
  output logic               seq_busy,
  output logic               seq_done
);

  typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_RAILS);
  localparam logic [DLY_W-1:0] CNT_ONE = DLY_W'(1);

  state_t             state, state_nxt;
  logic [LVL_W-1:0]   lvl_nxt;
  logic [DLY_W-1:0]   cnt, cnt_nxt;
  logic               done_nxt;
  logic [N_RAILS-1:0] rails_nxt;

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    rails_nxt = '0;
    case (state)
      S_OFF: begin
        if (lcd_on) begin
          state_nxt = S_UP;
          lvl_nxt   = LVL_ONE;
          cnt_nxt   = step_dly;
        end
      end
      S_UP: begin
        // Reversal wins over the dwell so a late off-request never waits.
        if (!lcd_on) begin
          state_nxt = S_DOWN;
          lvl_nxt   = lvl - LVL_ONE;
          cnt_nxt   = step_dly;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (lvl < LVL_MAX) begin
          lvl_nxt = lvl + LVL_ONE;
          cnt_nxt = step_dly;
        end else begin
          state_nxt = S_ON;
          done_nxt  = 1'b1;
        end
      end
      S_ON: begin
        if (!lcd_on) begin
          state_nxt = S_DOWN;
          lvl_nxt   = lvl - LVL_ONE;
          cnt_nxt   = step_dly;
        end
      end
      S_DOWN: begin
        if (lcd_on) begin
          state_nxt = S_UP;
          lvl_nxt   = lvl + LVL_ONE;
          cnt_nxt   = step_dly;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (lvl != '0) begin
          lvl_nxt = lvl - LVL_ONE;
          cnt_nxt = step_dly;
        end else begin
          state_nxt = S_OFF;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_OFF;
    endcase
    for (int i = 0; i < N_RAILS; i++) begin
      rails_nxt[i] = (lvl_nxt > LVL_W'(i));
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      state     <= S_OFF;
      lvl       <= '0;
      cnt       <= '0;
      rails_en  <= '0;
      lcd_ready <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      lvl       <= lvl_nxt;
      cnt       <= cnt_nxt;
      rails_en  <= rails_nxt;
      lcd_ready <= (state_nxt == S_ON);
      seq_busy  <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
      seq_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer: expected per-edge outputs are queued from closed-form timing
// when stimulus is applied, then popped and compared one per edge.
module tb_lcd_power_sequencer;

  localparam int N = 5;

  logic         clk_out = 1'b0;
  logic         rst = 1'b1;
  logic         lcd_on = 1'b0;
  logic [15:0]  step_dly = 16'd3;
  logic [N-1:0] rails_en;
  logic [2:0]   lvl;
  logic         lcd_ready, seq_busy, seq_done;

  typedef struct {
    int lvl;
    bit ready;
    bit busy;
    bit done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_out = ~clk_out;

  lcd_power_sequencer #(.N_RAILS(N), .DLY_W(16)) dut (
    .clk_out  (clk_out),
    .rst      (rst),
    .lcd_on   (lcd_on),
    .step_dly (step_dly),
    .rails_en (rails_en),
    .lvl      (lvl),
    .lcd_ready(lcd_ready),
    .seq_busy (seq_busy),
    .seq_done (seq_done)
  );

  function automatic logic [N-1:0] therm(input int l);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (i < l);
    return r;
  endfunction

  // Power-up from OFF with dwell d, relative to the first edge that samples lcd_on=1.
  function automatic void push_up(input int d, input int first, input int last);
    for (int t = first; t <= last; t++) begin
      if (t < N * d) sb.push_back('{lvl: t / d + 1, ready: 1'b0, busy: 1'b1, done: 1'b0});
      else           sb.push_back('{lvl: N, ready: 1'b1, busy: 1'b0, done: (t == N * d)});
    end
  endfunction

  // Power-down starting at level top (rail top-1 cleared at t=0), dwell d.
  function automatic void push_down(input int top, input int d, input int last);
    for (int t = 0; t <= last; t++) begin
      if (t < top * d) sb.push_back('{lvl: top - 1 - t / d, ready: 1'b0, busy: 1'b1, done: 1'b0});
      else             sb.push_back('{lvl: 0, ready: 1'b0, busy: 1'b0, done: (t == top * d)});
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; lcd_on = 1'b1; step_dly = 16'd3;
    for (int t = 0; t < 3; t++) sb.push_back('{lvl: 0, ready: 1'b0, busy: 1'b0, done: 1'b0});
    for (int t = 0; t < 3; t++) begin
      @(posedge clk_out); #1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL reset t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
    lcd_on = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    repeat (3) @(posedge clk_out);
    #1;
    lcd_on = 1'b1; step_dly = 16'd3;
    push_up(4, 0, 22);
    for (int t = 0; t <= 22; t++) begin
      @(posedge clk_out); #1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL power_up t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  task automatic test_power_down();
    lcd_on = 1'b0;
    push_down(N, 4, 22);
    for (int t = 0; t <= 22; t++) begin
      @(posedge clk_out); #1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL power_down t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reversal_up();
    lcd_on = 1'b1;
    push_up(4, 0, 8);
    for (int t = 0; t <= 8; t++) begin
      @(posedge clk_out); #1;
      if (t == 8) begin
        lcd_on = 1'b0;
        push_down(3, 4, 13);
      end
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL rev_up_rise t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
    for (int t = 0; t <= 13; t++) begin
      @(posedge clk_out); #1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL rev_up_fall t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reversal_down();
    step_dly = 16'd0;
    lcd_on = 1'b1;
    push_up(1, 0, 5);
    push_down(N, 1, 2);
    // Re-raised at level 2: one step per edge back to 5, ON one edge later.
    sb.push_back('{lvl: 3, ready: 1'b0, busy: 1'b1, done: 1'b0});
    sb.push_back('{lvl: 4, ready: 1'b0, busy: 1'b1, done: 1'b0});
    sb.push_back('{lvl: 5, ready: 1'b0, busy: 1'b1, done: 1'b0});
    sb.push_back('{lvl: 5, ready: 1'b1, busy: 1'b0, done: 1'b1});
    sb.push_back('{lvl: 5, ready: 1'b1, busy: 1'b0, done: 1'b0});
    for (int t = 0; t < 14; t++) begin
      @(posedge clk_out); #1;
      if (t == 5) lcd_on = 1'b0;
      if (t == 8) lcd_on = 1'b1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL rev_down t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_up();
    rst = 1'b1; lcd_on = 1'b0; step_dly = 16'd3;
    sb.push_back('{lvl: 0, ready: 1'b0, busy: 1'b0, done: 1'b0});
    push_up(4, 0, 8);
    sb.push_back('{lvl: 0, ready: 1'b0, busy: 1'b0, done: 1'b0});
    push_up(4, 0, 4);
    for (int t = 0; t < 16; t++) begin
      @(posedge clk_out); #1;
      if (t == 0) begin rst = 1'b0; lcd_on = 1'b1; end
      if (t == 9) rst = 1'b1;
      if (t == 10) rst = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL reset_mid_up t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  task automatic test_step_dly_change();
    rst = 1'b1; lcd_on = 1'b0; step_dly = 16'd3;
    sb.push_back('{lvl: 0, ready: 1'b0, busy: 1'b0, done: 1'b0});
    // Running dwell of 4 finishes; later reloads use dwell 2.
    for (int t = 0; t <= 13; t++) begin
      if (t < 4)       sb.push_back('{lvl: 1, ready: 1'b0, busy: 1'b1, done: 1'b0});
      else if (t < 12) sb.push_back('{lvl: 2 + (t - 4) / 2, ready: 1'b0, busy: 1'b1, done: 1'b0});
      else             sb.push_back('{lvl: N, ready: 1'b1, busy: 1'b0, done: (t == 12)});
    end
    for (int t = -1; t <= 13; t++) begin
      @(posedge clk_out); #1;
      if (t == -1) begin rst = 1'b0; lcd_on = 1'b1; end
      if (t == 1) step_dly = 16'd1;
      e = sb.pop_front();
      checks++;
      if ({lvl, rails_en, lcd_ready, seq_busy, seq_done} !== {3'(e.lvl), therm(e.lvl), e.ready, e.busy, e.done}) begin
        errors++;
        $display("FAIL step_dly_change t=%0d got lvl=%0d rails=%b rdy/bsy/dn=%b%b%b want lvl=%0d rdy/bsy/dn=%b%b%b",
                 t, lvl, rails_en, lcd_ready, seq_busy, seq_done, e.lvl, e.ready, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_reversal_up();
    test_reversal_down();
    test_reset_mid_up();
    test_step_dly_change();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_power_sequencer.md
# lcd_power_sequencer

Parametrised power-up/power-down sequencer for the TFT LCD panel, driving N ordered enable rails (TFT supply, DE/RGB/pixel/sync, DISP, backlight LED, …) from a single level request. Compared with the fixed five-step bring-up, it adds:

- a run-time programmable dwell between steps;
- reverse-order power-down;
- mid-sequence reversal;
- ready, busy and done status outputs.

It sits between the top-level LCD on/off control and the timing generator / backlight enables.

## Interface
Parameters:
- `N_RAILS`, 5: number of sequenced enable rails, legal range 1..16. Rail 0 powers up first and powers down last.
- `DLY_W`, 16: width of the dwell counter and of `step_dly`.
- `LVL_W`, `$clog2(N_RAILS+1)`: width of `lvl`.

Ports:
- `clk_out`, in, 1: pixel/system clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high; clock `clk_out`.
- `lcd_on`, in, 1: level request; 1 = panel on, 0 = panel off. Sampled every cycle.
- `step_dly`, in, `DLY_W`: dwell in cycles minus one between consecutive steps. Sampled at every counter reload.
- `rails_en`, out, `N_RAILS`: registered rail enables, always a thermometer code of `lvl` (bits `[lvl-1:0]` set).
- `lvl`, out, `LVL_W`: number of rails currently enabled, 0..`N_RAILS`.
- `lcd_ready`, out, 1: high only in state ON.
- `seq_busy`, out, 1: high in UP or DOWN.
- `seq_done`, out, 1: one-cycle pulse on the edge that enters ON or OFF.

## Operation
States: OFF, UP, ON, DOWN. Internal dwell counter `cnt` is `DLY_W` wide.

Reset, synchronous, overrides everything including mid-sequence:
- state = OFF, `lvl` = 0, `cnt` = 0;
- `rails_en` = 0, `lcd_ready` = 0, `seq_busy` = 0, `seq_done` = 0.

Rails drop immediately on reset; no orderly power-down is performed.

Transitions, evaluated per edge:
- **OFF**
  - `lcd_on` = 1: `lvl` ← 1, `cnt` ← `step_dly`, go to UP.
  - Otherwise stay in OFF.
- **UP**
  - `lcd_on` = 0 (reversal): `lvl` ← `lvl`−1, `cnt` ← `step_dly`, go to DOWN. This takes priority over the counter.
  - Else if `cnt` ≠ 0: `cnt` ← `cnt`−1.
  - Else if `lvl` < `N_RAILS`: `lvl` ← `lvl`+1, `cnt` ← `step_dly`.
  - Else (`lvl` = `N_RAILS`, final dwell expired): go to ON and pulse `seq_done`.
- **ON**
  - `lcd_on` = 0: `lvl` ← `lvl`−1 (top rail cleared), `cnt` ← `step_dly`, go to DOWN.
- **DOWN**
  - `lcd_on` = 1 (reversal): `lvl` ← `lvl`+1, `cnt` ← `step_dly`, go to UP.
  - Else if `cnt` ≠ 0: decrement `cnt`.
  - Else if `lvl` > 0: `lvl` ← `lvl`−1, reload `cnt`.
  - Else (`lvl` = 0, final dwell expired): go to OFF and pulse `seq_done`.

Invariants:
- `lvl` never leaves 0..`N_RAILS`.
- `rails_en` changes by at most one bit per cycle.
- In UP, `lvl` ≥ 1. In DOWN, `lvl` ≤ `N_RAILS`−1.
- A reversal in the UP final dwell (`lvl` = `N_RAILS`) clears rail `N_RAILS`−1.
- A reversal in the DOWN final dwell (`lvl` = 0) sets rail 0.
- `step_dly` = 0 gives one step per cycle.
- A change of `step_dly` affects only the next reload; the running count is not disturbed.
- `N_RAILS` = 1 is legal: one step plus one dwell in each direction.

## Timing
Let `D` = `step_dly`+1, held constant.

Power-up, `lcd_on` first sampled 1 in OFF at edge k:
- `rails_en[i]` rises at edge k + i·D.
- `lcd_ready` and `seq_done` rise at edge k + `N_RAILS`·D.
- `seq_busy` is high from edge k up to, but not including, that edge.

Power-down, `lcd_on` first sampled 0 in ON at edge m:
- `lcd_ready` falls at edge m.
- `rails_en[j]` falls at edge m + (`N_RAILS`−1−j)·D.
- OFF and `seq_done` at edge m + `N_RAILS`·D.

Latency from a request to the first rail change is 1 edge, and all outputs are registered. Reversal acts on the same edge it is sampled, with no wait for the dwell.

## Test plan
- **Power-up:** `N_RAILS`=5, `step_dly`=3, raise `lcd_on` at edge 10 → rails 0..4 rise at edges 10/14/18/22/26; `lcd_ready` and a 1-cycle `seq_done` at 30; `seq_busy` high 10..29.
- **Power-down:** from ON, drop `lcd_on` at edge 50 → `lcd_ready` low at 50; rails 4..0 fall at 50/54/58/62/66; OFF and `seq_done` at 70.
- **Reversal in UP:** `lcd_on` high at edge 10, low at edge 19 (`lvl`=3) → rail 2 falls at 19, rail 1 at 23, rail 0 at 27; OFF at 31; `lcd_ready` never asserts.
- **Reversal in DOWN, and `step_dly`=0:** down from ON, `lcd_on` high again at `lvl`=2 → `lvl` goes 3, 4, 5 on consecutive edges; ready one edge after `lvl`=5.
- **Reset mid-UP** at `lvl`=3 → next edge all outputs 0, state OFF. With `lcd_on` still high, the next edge restarts at `lvl`=1.
- **`step_dly` change:** change 3→1 while `cnt`=2 → the current dwell completes unchanged; subsequent steps are spaced 2 cycles apart.
